// File: rtl/stack_port_arbiter_if.sv
// Bundle between the stack arbiter, its two requesters, the stack RAM and status observers.
// slave is the arbiter's view; master is the view of the surrounding logic.
interface stack_port_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 7
);
   logic              req0_valid;
   logic              req0_pop;
   logic [DATA_W-1:0] req0_wdata;
   logic              req0_done;
   logic              req1_valid;
   logic              req1_pop;
   logic [DATA_W-1:0] req1_wdata;
   logic              req1_done;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [ADDR_W:0]   sp;
   logic              empty;
   logic              full;
   logic              busy;
   logic [ADDR_W:0]   max_depth;

   modport slave (
      input  req0_valid, req0_pop, req0_wdata,
      input  req1_valid, req1_pop, req1_wdata,
      output req0_done, req1_done,
      output rsp_rdata, rsp_err,
      output mem_addr, mem_we, mem_re, mem_wdata,
      input  mem_rdata,
      output sp, empty, full, busy, max_depth
   );

   modport master (
      output req0_valid, req0_pop, req0_wdata,
      output req1_valid, req1_pop, req1_wdata,
      input  req0_done, req1_done,
      input  rsp_rdata, rsp_err,
      input  mem_addr, mem_we, mem_re, mem_wdata,
      output mem_rdata,
      input  sp, empty, full, busy, max_depth
   );
endinterface

// File: rtl/stack_port_arbiter.sv
// Two-requester round-robin controller for a single-port LIFO RAM with 1-cycle read latency.
// Optional STACK_WATERMARK_EN adds a high-water-mark register on max_depth (tied to 0 otherwise).
module stack_port_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   stack_port_arbiter_if.slave  bus
);
   localparam logic [ADDR_W:0] DEPTH_SP = (ADDR_W+1)'(2**ADDR_W);

   typedef enum logic [2:0] {IDLE, PUSH, POP, POP_WAIT, RESP} state_t;

   state_t            r_state, w_state_next;
   logic [ADDR_W:0]   r_sp, w_sp_next;
   logic              r_last_grant, w_last_grant_next;
   logic              r_grant, w_grant_next;
   logic [DATA_W-1:0] r_wdata, w_wdata_next;
   logic [DATA_W-1:0] r_rdata, w_rdata_next;
   logic              r_err, w_err_next;

   logic [1:0]        w_valid;
   logic              w_winner;
   logic              w_win_pop;
   logic [DATA_W-1:0] w_win_wdata;
   logic              w_empty;
   logic              w_full;
   logic [ADDR_W:0]   w_sp_inc;
   logic [ADDR_W-1:0] w_pop_addr;
   logic [1:0]        w_done;

   assign w_valid     = {bus.req1_valid, bus.req0_valid};
   // On a tie the requester that did not win last time goes next.
   assign w_winner    = (&w_valid) ? ~r_last_grant : w_valid[1];
   assign w_win_pop   = w_winner ? bus.req1_pop   : bus.req0_pop;
   assign w_win_wdata = w_winner ? bus.req1_wdata : bus.req0_wdata;
   assign w_empty     = (r_sp == '0);
   assign w_full      = (r_sp == DEPTH_SP);
   assign w_sp_inc    = r_sp + 1'b1;
   // Low bits minus one also yield DEPTH-1 correctly when sp == DEPTH.
   assign w_pop_addr  = r_sp[ADDR_W-1:0] - ADDR_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_sp         <= '0;
         r_last_grant <= 1'b1;
         r_grant      <= 1'b0;
         r_wdata      <= '0;
         r_rdata      <= '0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_sp         <= w_sp_next;
         r_last_grant <= w_last_grant_next;
         r_grant      <= w_grant_next;
         r_wdata      <= w_wdata_next;
         r_rdata      <= w_rdata_next;
         r_err        <= w_err_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_sp_next         = r_sp;
      w_last_grant_next = r_last_grant;
      w_grant_next      = r_grant;
      w_wdata_next      = r_wdata;
      w_rdata_next      = r_rdata;
      w_err_next        = r_err;
      case (r_state)
         IDLE: begin
            if (|w_valid) begin
               w_last_grant_next = w_winner;
               w_grant_next      = w_winner;
               w_wdata_next      = w_win_wdata;
               if (!w_win_pop && w_full) begin
                  w_err_next   = 1'b1;
                  w_state_next = RESP;
               end else if (w_win_pop && w_empty) begin
                  w_err_next   = 1'b1;
                  w_rdata_next = '0;
                  w_state_next = RESP;
               end else if (w_win_pop) begin
                  w_state_next = POP;
               end else begin
                  w_state_next = PUSH;
               end
            end
         end
         PUSH: begin
            w_sp_next    = w_sp_inc;
            w_err_next   = 1'b0;
            w_state_next = RESP;
         end
         POP: begin
            w_sp_next    = r_sp - 1'b1;
            w_state_next = POP_WAIT;
         end
         POP_WAIT: begin
            w_rdata_next = bus.mem_rdata;
            w_err_next   = 1'b0;
            w_state_next = RESP;
         end
         RESP: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_done
         assign w_done[gi] = (r_state == RESP) && (r_grant == 1'(gi));
      end
   endgenerate

   assign bus.req0_done = w_done[0];
   assign bus.req1_done = w_done[1];
   assign bus.rsp_rdata = r_rdata;
   assign bus.rsp_err   = r_err;

   // RAM strobes come straight from the state register, so they can never overlap.
   assign bus.mem_we    = (r_state == PUSH);
   assign bus.mem_re    = (r_state == POP);
   assign bus.mem_addr  = (r_state == PUSH) ? r_sp[ADDR_W-1:0] :
                          (r_state == POP)  ? w_pop_addr : '0;
   assign bus.mem_wdata = (r_state == PUSH) ? r_wdata : '0;

   assign bus.sp    = r_sp;
   assign bus.empty = w_empty;
   assign bus.full  = w_full;
   assign bus.busy  = (r_state != IDLE);

`ifdef STACK_WATERMARK_EN
   logic [ADDR_W:0] r_max_depth;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_max_depth <= '0;
      end else if ((r_state == PUSH) && (w_sp_inc > r_max_depth)) begin
         r_max_depth <= w_sp_inc;
      end
   end

   assign bus.max_depth = r_max_depth;
`else
   assign bus.max_depth = '0;
`endif
endmodule

// File: tb/tb_stack_port_arbiter.sv
// Directed scoreboard bench: a 128-deep and a 4-deep instance, each with a behavioural sync RAM.
module tb_stack_port_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   stack_port_arbiter_if #(.DATA_W(8), .ADDR_W(7)) ia();
   stack_port_arbiter_if #(.DATA_W(8), .ADDR_W(2)) ib();

   stack_port_arbiter #(.DATA_W(8), .ADDR_W(7)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
   stack_port_arbiter #(.DATA_W(8), .ADDR_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

   logic [7:0] ram_a [128];
   logic [7:0] ram_b [4];

   always @(posedge clk) begin
      if (ia.mem_we) ram_a[ia.mem_addr] <= ia.mem_wdata;
      if (ia.mem_re) ia.mem_rdata <= ram_a[ia.mem_addr];
      if (ib.mem_we) ram_b[ib.mem_addr] <= ib.mem_wdata;
      if (ib.mem_re) ib.mem_rdata <= ram_b[ib.mem_addr];
   end

   typedef struct {
      int         req;
      bit         err;
      logic [7:0] rdata;
      int         lat;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   lat_a   = 0;
   int   lat_b   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic score(input string tag, input int d, input logic d0, input logic d1,
                        input logic err, input logic [7:0] rdata, input int lat);
      exp_t e;
      int   sz;
      sz = (d == 0) ? q_a.size() : q_b.size();
      check({tag, " done expected"}, 32'(sz != 0), 32'd1);
      if (sz != 0) begin
         if (d == 0) e = q_a.pop_front();
         else        e = q_b.pop_front();
         check({tag, " grant"}, 32'({d1, d0}), (e.req == 1) ? 32'd2 : 32'd1);
         check({tag, " rsp_err"}, 32'(err), 32'(e.err));
         check({tag, " rsp_rdata"}, 32'(rdata), 32'(e.rdata));
         check({tag, " latency"}, 32'(lat), 32'(e.lat));
         $display("[TB] %s done req%0d err=%0d rdata=0x%02h lat=%0d", tag, d1 ? 1 : 0, err, rdata, lat);
      end
   endtask

   // Monitors: count busy cycles since the last IDLE cycle and score every done pulse.
   always @(negedge clk) begin
      int lat_now;
      lat_now = ia.busy ? lat_a + 1 : 0;
      lat_a <= lat_now;
      if (ia.req0_done || ia.req1_done)
         score("A", 0, ia.req0_done, ia.req1_done, ia.rsp_err, ia.rsp_rdata, lat_now);
   end

   always @(negedge clk) begin
      int lat_now;
      lat_now = ib.busy ? lat_b + 1 : 0;
      lat_b <= lat_now;
      if (ib.req0_done || ib.req1_done)
         score("B", 1, ib.req0_done, ib.req1_done, ib.rsp_err, ib.rsp_rdata, lat_now);
   end

   task automatic drive(input int d, input int r, input logic v, input logic pop, input logic [7:0] data);
      if (d == 0) begin
         if (r == 0) begin ia.req0_valid = v; ia.req0_pop = pop; ia.req0_wdata = data; end
         else        begin ia.req1_valid = v; ia.req1_pop = pop; ia.req1_wdata = data; end
      end else begin
         if (r == 0) begin ib.req0_valid = v; ib.req0_pop = pop; ib.req0_wdata = data; end
         else        begin ib.req1_valid = v; ib.req1_pop = pop; ib.req1_wdata = data; end
      end
   endtask

   task automatic expect_rsp(input int d, input int r, input logic pop, input bit err, input logic [7:0] rdata);
      exp_t e;
      e.req   = r;
      e.err   = err;
      e.rdata = rdata;
      e.lat   = err ? 1 : (pop ? 3 : 2);
      if (d == 0) q_a.push_back(e);
      else        q_b.push_back(e);
   endtask

   task automatic start(input int d, input int r, input logic pop, input logic [7:0] data,
                        input bit err, input logic [7:0] rdata);
      expect_rsp(d, r, pop, err, rdata);
      $display("[TB] %s req%0d %s 0x%02h", (d == 0) ? "A" : "B", r, pop ? "pop " : "push", data);
      drive(d, r, 1'b1, pop, data);
   endtask

   task automatic finish_op(input int d, input int r, output int we_cnt);
      logic done;
      done   = 1'b0;
      we_cnt = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (d == 0) begin
            done   = (r == 0) ? ia.req0_done : ia.req1_done;
            we_cnt += int'(ia.mem_we);
         end else begin
            done   = (r == 0) ? ib.req0_done : ib.req1_done;
            we_cnt += int'(ib.mem_we);
         end
      end
      check("done within bound", 32'(done), 32'd1);
      @(posedge clk); #1;
      drive(d, r, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic op(input int d, input int r, input logic pop, input logic [7:0] data,
                     input bit err, input logic [7:0] rdata);
      int w;
      start(d, r, pop, data, err, rdata);
      finish_op(d, r, w);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int  w;
      int  cnt;
      bit  seen;
      drive(0, 0, 1'b0, 1'b0, 8'h00);
      drive(0, 1, 1'b0, 1'b0, 8'h00);
      drive(1, 0, 1'b0, 1'b0, 8'h00);
      drive(1, 1, 1'b0, 1'b0, 8'h00);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      check("reset sp", 32'(ia.sp), 32'd0);
      check("reset empty", 32'(ia.empty), 32'd1);
      check("reset full", 32'(ia.full), 32'd0);
      check("reset busy", 32'(ia.busy), 32'd0);
      check("reset mem_we", 32'(ia.mem_we), 32'd0);
      check("reset mem_re", 32'(ia.mem_re), 32'd0);
      check("reset mem_addr", 32'(ia.mem_addr), 32'd0);
      check("reset rsp_rdata", 32'(ia.rsp_rdata), 32'd0);
      check("reset max_depth", 32'(ia.max_depth), 32'd0);
      @(posedge clk); #1;

      // Push 0xA5: RAM write one cycle after acceptance
      start(0, 0, 1'b0, 8'hA5, 1'b0, 8'h00);
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         seen = ia.busy;
      end
      check("push busy seen", 32'(seen), 32'd1);
      check("push mem_we", 32'(ia.mem_we), 32'd1);
      check("push mem_re", 32'(ia.mem_re), 32'd0);
      check("push mem_addr", 32'(ia.mem_addr), 32'd0);
      check("push mem_wdata", 32'(ia.mem_wdata), 32'hA5);
      finish_op(0, 0, w);
      @(negedge clk);
      check("sp after push", 32'(ia.sp), 32'd1);
      check("empty after push", 32'(ia.empty), 32'd0);
      @(posedge clk); #1;

      op(0, 0, 1'b1, 8'h00, 1'b0, 8'hA5);

      // LIFO ordering across requesters; push responses keep the last pop data
      op(0, 0, 1'b0, 8'h11, 1'b0, 8'hA5);
      op(0, 0, 1'b0, 8'h22, 1'b0, 8'hA5);
      op(0, 1, 1'b1, 8'h00, 1'b0, 8'h22);
      op(0, 1, 1'b1, 8'h00, 1'b0, 8'h11);
      @(negedge clk);
      check("sp after pops", 32'(ia.sp), 32'd0);
      check("empty after pops", 32'(ia.empty), 32'd1);

      // Both requesters held valid from reset: strict alternation starting with req0
      do_reset();
      expect_rsp(0, 0, 1'b0, 1'b0, 8'h00);
      expect_rsp(0, 1, 1'b0, 1'b0, 8'h00);
      expect_rsp(0, 0, 1'b0, 1'b0, 8'h00);
      expect_rsp(0, 1, 1'b0, 1'b0, 8'h00);
      $display("[TB] A req0 push 0x01 and req1 push 0x02 held together");
      drive(0, 0, 1'b1, 1'b0, 8'h01);
      drive(0, 1, 1'b1, 1'b0, 8'h02);
      cnt = 0;
      for (int k = 0; k < 80 && cnt < 4; k++) begin
         @(negedge clk);
         if (ia.req0_done || ia.req1_done) cnt++;
      end
      check("tie done count", 32'(cnt), 32'd4);
      @(posedge clk); #1;
      drive(0, 0, 1'b0, 1'b0, 8'h00);
      drive(0, 1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      check("tie ram[0]", 32'(ram_a[0]), 32'h01);
      check("tie ram[1]", 32'(ram_a[1]), 32'h02);
      check("tie ram[2]", 32'(ram_a[2]), 32'h01);
      check("tie ram[3]", 32'(ram_a[3]), 32'h02);
      check("tie sp", 32'(ia.sp), 32'd4);
      @(posedge clk); #1;

      // Reset while in POP_WAIT abandons the pop with no done pulse
      $display("[TB] A req1 pop, reset during POP_WAIT");
      drive(0, 1, 1'b1, 1'b1, 8'h00);
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         seen = ia.mem_re;
      end
      check("pop mem_re seen", 32'(seen), 32'd1);
      check("pop mem_addr", 32'(ia.mem_addr), 32'd3);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort busy", 32'(ia.busy), 32'd0);
      check("abort sp", 32'(ia.sp), 32'd0);
      check("abort empty", 32'(ia.empty), 32'd1);
      check("abort req1_done", 32'(ia.req1_done), 32'd0);
      drive(0, 1, 1'b0, 1'b0, 8'h00);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("abort sp later", 32'(ia.sp), 32'd0);
      @(posedge clk); #1;

      // Watermark sequence: 3 pushes, 2 pops, 1 push
      op(0, 0, 1'b0, 8'h31, 1'b0, 8'h00);
      op(0, 0, 1'b0, 8'h32, 1'b0, 8'h00);
      op(0, 0, 1'b0, 8'h33, 1'b0, 8'h00);
      op(0, 0, 1'b1, 8'h00, 1'b0, 8'h33);
      op(0, 0, 1'b1, 8'h00, 1'b0, 8'h32);
      op(0, 0, 1'b0, 8'h34, 1'b0, 8'h32);
      @(negedge clk);
      check("wm sp", 32'(ia.sp), 32'd2);
`ifdef STACK_WATERMARK_EN
      check("max_depth", 32'(ia.max_depth), 32'd3);
`else
      check("max_depth tied", 32'(ia.max_depth), 32'd0);
`endif
      @(posedge clk); #1;

      // 4-deep instance: overflow then underflow
      op(1, 1, 1'b0, 8'hB0, 1'b0, 8'h00);
      op(1, 1, 1'b0, 8'hB1, 1'b0, 8'h00);
      op(1, 1, 1'b0, 8'hB2, 1'b0, 8'h00);
      op(1, 1, 1'b0, 8'hB3, 1'b0, 8'h00);
      start(1, 1, 1'b0, 8'hB4, 1'b1, 8'h00);
      finish_op(1, 1, w);
      check("B overflow mem_we cycles", 32'(w), 32'd0);
      @(negedge clk);
      check("B sp full", 32'(ib.sp), 32'd4);
      check("B full", 32'(ib.full), 32'd1);
`ifdef STACK_WATERMARK_EN
      check("B max_depth", 32'(ib.max_depth), 32'd4);
`endif
      @(posedge clk); #1;
      op(1, 0, 1'b1, 8'h00, 1'b0, 8'hB3);
      op(1, 0, 1'b1, 8'h00, 1'b0, 8'hB2);
      op(1, 0, 1'b1, 8'h00, 1'b0, 8'hB1);
      op(1, 0, 1'b1, 8'h00, 1'b0, 8'hB0);
      op(1, 0, 1'b1, 8'h00, 1'b1, 8'h00);
      @(negedge clk);
      check("B sp empty", 32'(ib.sp), 32'd0);
      check("B empty", 32'(ib.empty), 32'd1);
      check("B not full", 32'(ib.full), 32'd0);

      repeat (2) @(negedge clk);
      check("A scoreboard drained", 32'(q_a.size()), 32'd0);
      check("B scoreboard drained", 32'(q_b.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
